// File: rtl/am_pkg.sv
// am_pkg: carrier and sample geometry shared by the AM modulator and demodulator
package am_pkg;
  localparam int CAR_LEN = 256;
  localparam int DATA_W = 8;
  localparam int BLK_LOG2 = $clog2(CAR_LEN);
  localparam int MAG_W = DATA_W - 1;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic [MAG_W-1:0] mag_t;
endpackage

// File: rtl/am_envelope_demod_if.sv
// am_envelope_demod_if: sample input, restart and envelope valid/ready output bundle
interface am_envelope_demod_if #(parameter int DATA_W = am_pkg::DATA_W);
  logic clr;
  logic in_valid;
  logic [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_env;
  logic [DATA_W-1:0] out_mean;
  logic overrun;
  modport master (
    output clr, in_valid, in_data, out_ready,
    input out_valid, out_env, out_mean, overrun
  );
  modport slave (
    input clr, in_valid, in_data, out_ready,
    output out_valid, out_env, out_mean, overrun
  );
endinterface

// File: rtl/am_env_iir.sv
// am_env_iir: first-order IIR over block means; carries the mean alongside the smoothed envelope
module am_env_iir import am_pkg::*; #(
  parameter int MEAN_W = MAG_W,
  parameter int ALPHA_SHIFT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [MEAN_W-1:0] in_mean,
  output logic              out_valid,
  output logic [MEAN_W-1:0] out_env,
  output logic [MEAN_W-1:0] out_mean
);
  localparam int FACC_W = MEAN_W + ALPHA_SHIFT;
  logic [FACC_W-1:0] facc_q, facc_d;
  logic [MEAN_W-1:0] env_q, env_d, mean_q, mean_d;
  logic valid_q, valid_d;
  always_comb begin
    facc_d = facc_q;
    env_d = env_q;
    mean_d = mean_q;
    valid_d = in_valid & ~clr;
    if (clr) facc_d = '0;
    else if (in_valid) begin
      // facc holds env scaled by 2^ALPHA_SHIFT; with a zero shift this collapses to the mean
      facc_d = facc_q + FACC_W'(in_mean) - (facc_q >> ALPHA_SHIFT);
      env_d = MEAN_W'(facc_d >> ALPHA_SHIFT);
      mean_d = in_mean;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      facc_q <= '0;
      env_q <= '0;
      mean_q <= '0;
      valid_q <= 1'b0;
    end else begin
      facc_q <= facc_d;
      env_q <= env_d;
      mean_q <= mean_d;
      valid_q <= valid_d;
    end
  assign out_valid = valid_q;
  assign out_env = env_q;
  assign out_mean = mean_q;
endmodule

// File: rtl/am_envelope_demod.sv
// am_envelope_demod: full-wave rectify, per-carrier-period mean, IIR envelope on a valid/ready output
module am_envelope_demod #(
  parameter int DATA_W = am_pkg::DATA_W,
  parameter int BLK_LOG2 = am_pkg::BLK_LOG2,
  parameter int ALPHA_SHIFT = 3
) (
  input logic clk,
  input logic reset,
  am_envelope_demod_if.slave bus
);
  localparam int MAG_W = DATA_W - 1;
  localparam int ACC_W = MAG_W + BLK_LOG2;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {MAG_W{1'b0}}};
  logic [MAG_W-1:0] mag;
  logic [ACC_W-1:0] sum, acc_q, acc_d;
  logic [BLK_LOG2-1:0] cnt_q, cnt_d;
  logic [MAG_W-1:0] blk_mean_q, blk_mean_d;
  logic s1_v_q, s1_v_d;
  logic take, close, drain, load;
  logic s2_v;
  logic [MAG_W-1:0] s2_env, s2_mean;
  logic out_valid_q, out_valid_d;
  logic [MAG_W-1:0] out_env_q, out_env_d, out_mean_q, out_mean_d;
  logic overrun_q, overrun_d;
  always_comb begin
    mag = bus.in_data == MOST_NEG ? '1 : bus.in_data[DATA_W-1] ? MAG_W'(-bus.in_data) : bus.in_data[MAG_W-1:0];
    take = bus.in_valid & ~bus.clr;
    close = take & (&cnt_q);
    sum = acc_q + ACC_W'(mag);
    // the closing sample belongs to the block it closes, so the next block starts from an empty accumulator
    acc_d = (bus.clr | close) ? '0 : take ? sum : acc_q;
    cnt_d = bus.clr ? '0 : cnt_q + BLK_LOG2'(take);
    blk_mean_d = close ? MAG_W'(sum >> BLK_LOG2) : blk_mean_q;
    s1_v_d = close;
    drain = out_valid_q & bus.out_ready;
    load = s2_v & (~out_valid_q | drain);
    out_valid_d = load | (out_valid_q & ~drain);
    out_env_d = load ? s2_env : out_env_q;
    out_mean_d = load ? s2_mean : out_mean_q;
    overrun_d = bus.clr ? 1'b0 : overrun_q | (s2_v & ~load);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      blk_mean_q <= '0;
      s1_v_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_env_q <= '0;
      out_mean_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      blk_mean_q <= blk_mean_d;
      s1_v_q <= s1_v_d;
      out_valid_q <= out_valid_d;
      out_env_q <= out_env_d;
      out_mean_q <= out_mean_d;
      overrun_q <= overrun_d;
    end
  am_env_iir #(.MEAN_W(MAG_W), .ALPHA_SHIFT(ALPHA_SHIFT)) u_iir (
    .clk(clk),
    .reset(reset),
    .clr(bus.clr),
    .in_valid(s1_v_q),
    .in_mean(blk_mean_q),
    .out_valid(s2_v),
    .out_env(s2_env),
    .out_mean(s2_mean)
  );
  assign bus.out_valid = out_valid_q;
  assign bus.out_env = {1'b0, out_env_q};
  assign bus.out_mean = {1'b0, out_mean_q};
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_am_envelope_demod.sv
// tb_am_envelope_demod: two DUTs (bypass and shift-3 filter) on shared stimulus, checked against a block-level model
module tb_am_envelope_demod;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int due; int mean; int e3;} res_t;
  res_t pend[$];
  int m_cnt = 0, m_sum = 0, m_facc = 0, m_cyc = 0, m_mean = 0, m_e3 = 0;
  bit m_v = 0, m_ovr = 0;
  always #5 clk = ~clk;
  am_envelope_demod_if #(.DATA_W(8)) ia ();
  am_envelope_demod_if #(.DATA_W(8)) ib ();
  assign ia.clr = clr;
  assign ia.in_valid = in_valid;
  assign ia.in_data = in_data;
  assign ia.out_ready = out_ready;
  assign ib.clr = clr;
  assign ib.in_valid = in_valid;
  assign ib.in_data = in_data;
  assign ib.out_ready = out_ready;
  am_envelope_demod #(.DATA_W(8), .BLK_LOG2(8), .ALPHA_SHIFT(0)) dut_a (.clk(clk), .reset(reset), .bus(ia));
  am_envelope_demod #(.DATA_W(8), .BLK_LOG2(8), .ALPHA_SHIFT(3)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  function automatic int mag(logic [7:0] d);
    int s = $signed(d);
    return s == -128 ? 127 : (s < 0 ? -s : s);
  endfunction
  function automatic logic [35:0] dut_state();
    return {ia.out_valid, ia.out_mean, ia.out_env, ia.overrun, ib.out_valid, ib.out_mean, ib.out_env, ib.overrun};
  endfunction
  function automatic logic [35:0] mdl_state();
    return {m_v, 8'(m_mean), 8'(m_mean), m_ovr, m_v, 8'(m_mean), 8'(m_e3), m_ovr};
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_sum = 0; m_facc = 0; m_mean = 0; m_e3 = 0; m_v = 0; m_ovr = 0;
    pend.delete();
  endtask
  task automatic model_edge(input bit v, input logic [7:0] d, input bit c, input bit r);
    bit fire = m_v && r;
    bit ld = 0;
    int mean;
    if (pend.size() > 0 && pend[0].due == m_cyc) begin
      if (!m_v || fire) begin ld = 1; m_mean = pend[0].mean; m_e3 = pend[0].e3; end
      else m_ovr = 1;
      pend.delete(0);
    end
    m_v = ld || (m_v && !fire);
    if (c) begin
      m_cnt = 0; m_sum = 0; m_facc = 0; m_ovr = 0;
      if (pend.size() > 0 && pend[0].due == m_cyc + 1) pend.delete(0);
    end else if (v) begin
      m_sum += mag(d);
      m_cnt++;
      if (m_cnt == 256) begin
        mean = m_sum / 256;
        m_facc = m_facc + mean - m_facc / 8;
        pend.push_back('{m_cyc + 2, mean, m_facc / 8});
        m_cnt = 0; m_sum = 0;
      end
    end
    m_cyc++;
  endtask
  task automatic step(input bit v, input logic [7:0] d, input bit c);
    in_valid = v; in_data = d; clr = c;
    @(posedge clk);
    model_edge(v, d, c, out_ready);
    #1;
  endtask
  task automatic test_reset();
    in_valid = 1; in_data = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_state() !== 36'h0) begin n_bad++; $display("FAIL reset_hold: got %h want 0", dut_state()); end
    reset = 0;
    step(0, 8'h00, 0);
    n_cmp++;
    if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL reset_release: got %h want %h", dut_state(), mdl_state()); end
  endtask
  task automatic test_const();
    out_ready = 1;
    for (int i = 0; i < 256; i++) begin
      step(1, 8'h40, 0);
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL const cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
    end
    step(0, 8'h00, 0);
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin n_bad++; $display("FAIL const_early: out_valid %b want 0", ia.out_valid); end
    step(0, 8'h00, 0);
    n_cmp++;
    if ({ia.out_valid, ia.out_mean, ia.out_env, ib.out_env} !== {1'b1, 8'd64, 8'd64, 8'd8}) begin
      n_bad++; $display("FAIL const_result: got v%b m%0d e0 %0d e3 %0d want v1 m64 e0 64 e3 8", ia.out_valid, ia.out_mean, ia.out_env, ib.out_env);
    end
    step(0, 8'h00, 0);
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin n_bad++; $display("FAIL const_pulse: out_valid %b want 0", ia.out_valid); end
  endtask
  task automatic test_sat();
    step(0, 8'h00, 1);
    for (int i = 0; i < 258; i++) begin
      step(i < 256, 8'h80, 0);
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL sat cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
    end
    n_cmp++;
    if ({ia.out_valid, ia.out_mean, ia.out_env, ib.out_env} !== {1'b1, 8'd127, 8'd127, 8'd15}) begin
      n_bad++; $display("FAIL sat_result: got v%b m%0d e0 %0d e3 %0d want v1 m127 e0 127 e3 15", ia.out_valid, ia.out_mean, ia.out_env, ib.out_env);
    end
    for (int i = 0; i < 258; i++) begin
      step(i < 256, i[0] ? 8'hFB : 8'h05, 0);
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL alt cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
    end
    n_cmp++;
    if ({ia.out_valid, ia.out_mean, ia.out_env, ib.out_env} !== {1'b1, 8'd5, 8'd5, 8'd14}) begin
      n_bad++; $display("FAIL alt_result: got v%b m%0d e0 %0d e3 %0d want v1 m5 e0 5 e3 14", ia.out_valid, ia.out_mean, ia.out_env, ib.out_env);
    end
    step(0, 8'h00, 0);
  endtask
  task automatic test_carrier();
    logic [7:0] tbl [256];
    int ref_mean = 0, nres = 0, prev = 0;
    for (int i = 0; i < 256; i++) begin
      tbl[i] = 8'($rtoi(127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0)));
      ref_mean += mag(tbl[i]);
    end
    ref_mean = ref_mean / 256;
    step(0, 8'h00, 1);
    for (int i = 0; i < 1027; i++) begin
      step(i < 1024, tbl[i % 256], 0);
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL carrier cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
      if (ia.out_valid) begin
        nres++;
        n_cmp++;
        if (ia.out_mean !== 8'(ref_mean) || int'(ib.out_env) < prev || (nres == 1 && ib.out_env !== 8'(ref_mean / 8))) begin
          n_bad++; $display("FAIL carrier_blk %0d: mean %0d env %0d prev %0d want mean %0d", nres, ia.out_mean, ib.out_env, prev, ref_mean);
        end
        prev = int'(ib.out_env);
      end
    end
    n_cmp++;
    if (nres != 4) begin n_bad++; $display("FAIL carrier_count: got %0d results want 4", nres); end
  endtask
  task automatic test_overrun();
    int s1 = 0;
    logic [7:0] d;
    out_ready = 0;
    step(0, 8'h00, 1);
    for (int i = 0; i < 515; i++) begin
      d = i < 256 ? 8'($urandom_range(40, 0)) : 8'($urandom_range(127, 90));
      if (i < 256) s1 += mag(d);
      step(i < 512, d, 0);
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL overrun cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
    end
    n_cmp++;
    if ({ia.out_valid, ia.out_mean, ia.overrun} !== {1'b1, 8'(s1 / 256), 1'b1}) begin
      n_bad++; $display("FAIL overrun_hold: got v%b m%0d ovr%b want v1 m%0d ovr1", ia.out_valid, ia.out_mean, ia.overrun, s1 / 256);
    end
    step(0, 8'h00, 1);
    n_cmp++;
    if ({ia.out_valid, ia.out_mean, ia.overrun, ib.overrun} !== {1'b1, 8'(s1 / 256), 2'b00}) begin
      n_bad++; $display("FAIL overrun_clr: got v%b m%0d ovr%b%b want v1 m%0d ovr0", ia.out_valid, ia.out_mean, ia.overrun, ib.overrun, s1 / 256);
    end
    out_ready = 1;
    step(0, 8'h00, 0);
    n_cmp++;
    if (ia.out_valid !== 1'b0 || ib.out_valid !== 1'b0) begin n_bad++; $display("FAIL overrun_drain: out_valid %b%b want 00", ia.out_valid, ib.out_valid); end
  endtask
  task automatic test_gaps();
    logic [7:0] s [512];
    int ea[$];
    int k = 0, nb = 0;
    bit v;
    foreach (s[i]) s[i] = 8'($urandom);
    out_ready = 1;
    step(0, 8'h00, 1);
    for (int i = 0; i < 515; i++) begin
      step(i < 512, i < 512 ? s[i] : 8'h00, 0);
      if (m_v) ea.push_back(m_mean * 256 + m_e3);
    end
    step(0, 8'h00, 1);
    for (int c = 0; c < 2100; c++) begin
      v = k < 512 && $urandom_range(1, 0) == 1;
      step(v, v ? s[k] : 8'($urandom), 0);
      if (v) k++;
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL gaps cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
      if (ia.out_valid) begin
        n_cmp++;
        if (nb >= ea.size() || {ia.out_mean, ib.out_env} !== {8'(ea[nb] / 256), 8'(ea[nb] % 256)}) begin
          n_bad++; $display("FAIL gaps_blk %0d: got m%0d e%0d vs gap-free run", nb, ia.out_mean, ib.out_env);
        end
        nb++;
      end
    end
    n_cmp++;
    if (k != 512 || nb != 2 || ea.size() != 2) begin n_bad++; $display("FAIL gaps_count: fed %0d got %0d want 512/2", k, nb); end
    for (int i = 0; i < 100; i++) step(1, 8'($urandom), 0);
    step(1, 8'h7F, 1);
    k = 0;
    for (int c = 0; c < 1200 && k < 256; c++) begin
      v = $urandom_range(1, 0) == 1;
      step(v, 8'($urandom), 0);
      if (v) k++;
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL clr100 cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
    end
    step(0, 8'h00, 0);
    n_cmp++;
    if (ia.out_valid !== 1'b0) begin n_bad++; $display("FAIL clr100_early: out_valid %b want 0", ia.out_valid); end
    step(0, 8'h00, 0);
    n_cmp++;
    if (ia.out_valid !== 1'b1) begin n_bad++; $display("FAIL clr100_late: out_valid %b want 1", ia.out_valid); end
    step(0, 8'h00, 0);
  endtask
  task automatic test_async_reset();
    out_ready = 0;
    step(0, 8'h00, 1);
    for (int i = 0; i < 296; i++) begin
      step(1, 8'($urandom), 0);
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL prereset cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
    end
    #3 reset = 1;
    #1;
    n_cmp++;
    if (dut_state() !== 36'h0) begin n_bad++; $display("FAIL async_reset: got %h want 0", dut_state()); end
    model_reset();
    #2 reset = 0;
    out_ready = 1;
    for (int i = 0; i < 258; i++) begin
      step(i < 256, 8'h20, 0);
      n_cmp++;
      if (dut_state() !== mdl_state()) begin n_bad++; $display("FAIL postreset cyc %0d: got %h want %h", m_cyc, dut_state(), mdl_state()); end
    end
    n_cmp++;
    if ({ia.out_valid, ia.out_mean, ia.out_env, ib.out_env} !== {1'b1, 8'd32, 8'd32, 8'd4}) begin
      n_bad++; $display("FAIL postreset_result: got v%b m%0d e0 %0d e3 %0d want v1 m32 e0 32 e3 4", ia.out_valid, ia.out_mean, ia.out_env, ib.out_env);
    end
  endtask
  initial begin
    test_reset();
    test_const();
    test_sat();
    test_carrier();
    test_overrun();
    test_gaps();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
